// File: rtl/spram_arb_pkg.sv
// Shared definitions for the single-port SRAM arbiter.
//   - arb_state_e : arbiter state encoding (ARB = free round-robin, LOCK = burst owner held)
//   - DEF_*       : default parameter values used by spram_arb
//   - LANE_W      : bits per byte lane; lanes() gives the strobe width for a data width
//   - STAT_W      : width of the optional statistics counters (SPRAM_ARB_STAT_EN)
package spram_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_LOCK   = 16;

  localparam int LANE_W = 8;
  localparam int STAT_W = 16;

  function automatic int lanes(input int data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/spram_arb_rr_pick.sv
// Round-robin priority encoder: picks the first asserted bit of valid at or
// after ptr, wrapping modulo N. Purely combinational, reusable by any arbiter.
// Ports:
//   valid : request vector
//   ptr   : highest-priority index this cycle (must be < N)
//   grant : one-hot grant, all-zero when nothing is valid
//   idx   : binary index of the grant (0 when nothing is valid)
//   any   : at least one request valid
module spram_arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/spram_arb.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// At most one access per cycle; a requester holding req_lock_i keeps the grant
// for up to MAX_LOCK consecutive beats. Responses return one cycle after
// acceptance; read data is the SRAM output passed straight through.
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   req_valid/ready/lock    : per-requester handshake and burst lock
//   req_addr/wdata/wstrb    : packed per-requester access (wstrb==0 means read)
//   rsp_valid_o, rsp_rdata_o: per-requester response strobe, shared read data
//   ram_*                   : SRAM macro interface (byte write enables active-low)
// Optional (define SPRAM_ARB_STAT_EN):
//   stat_clr_i, stat_grant_cnt_o, stat_stall_cnt_o : saturating usage counters
module spram_arb
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
`ifdef SPRAM_ARB_STAT_EN
  input  logic                                stat_clr_i,
  output logic [NUM_REQ*STAT_W-1:0]           stat_grant_cnt_o,
  output logic [STAT_W-1:0]                   stat_stall_cnt_o,
`endif
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic [DATA_WIDTH/8-1:0]             ram_wenb_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_o,
  output logic [DATA_WIDTH-1:0]               ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]               ram_rdata_i
);

  localparam int NB = lanes(DATA_WIDTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK);

  arb_state_e          state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [IW-1:0]       owner, owner_nxt;
  logic [CW-1:0]       lock_cnt, lock_cnt_nxt;
  logic [NUM_REQ-1:0]  last_grant;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       gidx;
  logic                gany;

  spram_arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant and next-state. gidx stays 0 without a grant so the RAM sees
  // requester 0's address/data (harmless, write enables are all high).
  always_comb begin
    grant        = '0;
    gidx         = '0;
    gany         = 1'b0;
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    case (state)
      ST_ARB: begin
        grant = pick_grant;
        gidx  = pick_idx;
        gany  = pick_any;
        if (pick_any) begin
          ptr_nxt = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (req_lock_i[pick_idx]) begin
            state_nxt    = ST_LOCK;
            owner_nxt    = pick_idx;
            lock_cnt_nxt = CW'(1);
          end
        end
      end
      ST_LOCK: begin
        // Pointer was already moved past the owner when the lock began.
        if (req_valid_i[owner]) begin
          gany         = 1'b1;
          gidx         = owner;
          grant[owner] = 1'b1;
          if (!req_lock_i[owner] || lock_cnt == CW'(MAX_LOCK - 1)) begin
            state_nxt    = ST_ARB;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 1'b1;
          end
        end else begin
          state_nxt    = ST_ARB;
          lock_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  assign req_ready_o = grant;
  assign ram_addr_o  = req_addr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_wdata_o = req_wdata_i[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign ram_wenb_o  = gany ? ~req_wstrb_i[gidx*NB +: NB] : '1;
  assign rsp_valid_o = last_grant;
  assign rsp_rdata_o = ram_rdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_ARB;
      ptr        <= '0;
      owner      <= '0;
      lock_cnt   <= '0;
      last_grant <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      last_grant <= grant;
    end
  end

`ifdef SPRAM_ARB_STAT_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic stall;
  assign stall = |(req_valid_i & ~grant);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_grant_cnt_o <= '0;
      stat_stall_cnt_o <= '0;
    end else if (stat_clr_i) begin
      stat_grant_cnt_o <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i])
          stat_grant_cnt_o[i*STAT_W +: STAT_W] <= sat_inc(stat_grant_cnt_o[i*STAT_W +: STAT_W]);
      end
      if (stall)
        stat_stall_cnt_o <= sat_inc(stat_stall_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_spram_arb.sv
// Bench for spram_arb (2 requesters, 14-bit address, 32-bit data, lock limit 16).
// Includes a registered SRAM model and a reference model of the arbitration
// rules and memory contents; statistics checks build only with SPRAM_ARB_STAT_EN.
module tb_spram_arb;

  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int ML = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_lock;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*NB-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata, ram_wdata, ram_rdata;
  logic [NB-1:0]   ram_wenb;
  logic [AW-1:0]   ram_addr;
`ifdef SPRAM_ARB_STAT_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_grant_cnt;
  logic [15:0]     stat_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spram_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
`ifdef SPRAM_ARB_STAT_EN
    .stat_clr_i       (stat_clr),
    .stat_grant_cnt_o (stat_grant_cnt),
    .stat_stall_cnt_o (stat_stall_cnt),
`endif
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_lock_i  (req_lock),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .ram_wenb_o  (ram_wenb),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  // SRAM model: byte-masked write, read data one cycle after the address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (!ram_wenb[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: rr priority, burst ownership with a beat count, memory image.
  int            m_ptr, m_owner, m_cnt;
  bit            m_lock;
  logic [N-1:0]  exp_rsp;
  bit            exp_rd;
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [NB-1:0] exp_wenb(input int g);
    if (g < 0) return '1;
    return ~req_wstrb[g*NB +: NB];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 0;
    exp_rsp = '0; exp_rd = 0; exp_rdata = '0;
  endtask

  task automatic model_step(input int g);
    logic [AW-1:0] a;
    logic [NB-1:0] s;
    logic [DW-1:0] d, w;
    exp_rsp = oh(g);
    exp_rd  = 0;
    if (m_lock) begin
      if (g < 0) m_lock = 0;
      else begin
        m_cnt++;
        if (!req_lock[g] || m_cnt >= ML) m_lock = 0;
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (req_lock[g]) begin m_lock = 1; m_owner = g; m_cnt = 1; end
    end
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      s = req_wstrb[g*NB +: NB];
      d = req_wdata[g*DW +: DW];
      if (s == '0) begin
        if (ref_mem.exists(a)) begin
          exp_rdata = ref_mem[a];
          exp_rd    = !$isunknown(exp_rdata);
        end
      end else begin
        w = ref_mem.exists(a) ? ref_mem[a] : 'x;
        for (int b = 0; b < NB; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = w;
      end
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] s);
    req_valid[i] = v;
    req_lock[i]  = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*NB +: NB] = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
`ifdef SPRAM_ARB_STAT_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_chk++; if (ram_wenb !== 4'hF) begin n_fail++; $display("FAIL reset_wenb: got %h want f", ram_wenb); end
    n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write_read();
    int g;
    set_req(0, 1, 0, 14'h0010, 32'hDEADBEEF, 4'hF);
    set_req(1, 0, 0, 14'h0000, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b want 01", req_ready); end
    n_chk++; if (ram_wenb !== 4'h0) begin n_fail++; $display("FAIL wr_wenb: got %h want 0", ram_wenb); end
    n_chk++; if (ram_addr !== 14'h0010 || ram_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_addr_data: got %h/%h want 0010/deadbeef", ram_addr, ram_wdata); end
    model_step(g);
    next_cycle();
    set_req(0, 1, 0, 14'h0010, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL wr_rsp: got %b want 01", rsp_valid); end
    n_chk++; if (ram_wenb !== 4'hF) begin n_fail++; $display("FAIL rd_wenb: got %h want f", ram_wenb); end
    model_step(g);
    next_cycle();
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_rsp: got %b want 01", rsp_valid); end
    n_chk++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rsp_rdata); end
    n_chk++; if (ram_wenb !== 4'hF) begin n_fail++; $display("FAIL idle_wenb: got %h want f", ram_wenb); end
    model_step(g);
    next_cycle();
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] dv [3];
    logic [NB-1:0] sv [3];
    int g;
    dv = '{32'hFFFFFFFF, 32'h00AB0000, 32'h0};
    sv = '{4'hF, 4'b0100, 4'h0};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_req(0, 1, 0, 14'h0020, dv[i], sv[i]);
      else       set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
      g = exp_grant(req_valid);
      @(negedge clk);
      if (i == 1) begin
        n_chk++; if (ram_wenb !== 4'b1011) begin n_fail++; $display("FAIL bw_wenb: got %b want 1011", ram_wenb); end
      end
      if (i == 3) begin
        n_chk++; if (rsp_rdata !== 32'hFFABFFFF) begin n_fail++; $display("FAIL bw_data: got %h want ffabffff", rsp_rdata); end
      end
      n_chk++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL bw_rsp: got %b want %b", rsp_valid, exp_rsp); end
      model_step(g);
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int g;
    logic [N-1:0] prev;
    set_req(0, 1, 0, 14'h0010, 32'h0, 4'h0);
    set_req(1, 1, 0, 14'h0020, 32'h0, 4'h0);
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      g = exp_grant(req_valid);
      @(negedge clk);
      n_chk++; if (req_ready !== oh(g) || !$onehot(req_ready) || req_ready === prev) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, req_ready, oh(g)); end
      n_chk++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %b want %b", i, rsp_valid, exp_rsp); end
      if (exp_rd) begin
        n_chk++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rsp_rdata, exp_rdata); end
      end
      prev = req_ready;
      model_step(g);
      next_cycle();
    end
  endtask

  task automatic test_lock();
    int g, run;
    bit seen0;
    run = 0; seen0 = 0;
    set_req(0, 0, 0, 14'h0010, 32'h0, 4'h0);
    set_req(1, 1, 1, 14'h0030, 32'h12345678, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (i == 1) req_valid[0] = 1'b1;
      g = exp_grant(req_valid);
      @(negedge clk);
      n_chk++; if (req_ready !== oh(g)) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b want %b", i, req_ready, oh(g)); end
      n_chk++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL lock_rsp[%0d]: got %b want %b", i, rsp_valid, exp_rsp); end
      if (!seen0) begin
        if (req_ready === 2'b10) run++;
        else if (req_ready === 2'b01) seen0 = 1;
      end
      model_step(g);
      next_cycle();
    end
    n_chk++; if (run != ML || !seen0) begin n_fail++; $display("FAIL lock_run: got %0d beats then req0=%0d want %0d then 1", run, seen0, ML); end
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    set_req(1, 0, 0, 14'h0, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (req_ready !== 2'b00 || rsp_valid !== exp_rsp) begin
      n_fail++; $display("FAIL lock_idle: got %b/%b want 00/%b", req_ready, rsp_valid, exp_rsp); end
    model_step(g);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int g;
    set_req(0, 1, 1, 14'h0010, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_ready: got %b want 01", req_ready); end
    model_step(g);
    next_cycle();
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    #1;
    n_chk++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rm_pending: got %b want 01", rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_rsp_drop: got %b want 00", rsp_valid); end
    n_chk++; if (ram_wenb !== 4'hF) begin n_fail++; $display("FAIL rm_wenb: got %h want f", ram_wenb); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    set_req(0, 1, 0, 14'h0010, 32'h0, 4'h0);
    set_req(1, 1, 0, 14'h0020, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    @(negedge clk);
    n_chk++; if (req_ready !== 2'b01 || req_ready !== oh(g)) begin n_fail++; $display("FAIL rm_ptr: got %b want 01", req_ready); end
    n_chk++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_no_rsp: got %b want 00", rsp_valid); end
    model_step(g);
    next_cycle();
  endtask

  task automatic test_random();
    int g;
    set_req(1, 0, 0, 14'h0, 32'h0, 4'h0);
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1, 0, 14'(a), $urandom, 4'hF);
      g = exp_grant(req_valid);
      @(negedge clk);
      n_chk++; if (req_ready !== oh(g)) begin n_fail++; $display("FAIL pre_ready[%0d]: got %b want %b", a, req_ready, oh(g)); end
      model_step(g);
      next_cycle();
    end
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++)
        set_req(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
                $urandom, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)));
      g = exp_grant(req_valid);
      @(negedge clk);
      n_chk++; if (req_ready !== oh(g)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, req_ready, oh(g)); end
      n_chk++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got %b want %b", i, rsp_valid, exp_rsp); end
      n_chk++; if (ram_wenb !== exp_wenb(g)) begin n_fail++; $display("FAIL rnd_wenb[%0d]: got %b want %b", i, ram_wenb, exp_wenb(g)); end
      if (g >= 0) begin
        n_chk++; if (ram_addr !== req_addr[g*AW +: AW]) begin
          n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ram_addr, req_addr[g*AW +: AW]); end
      end
      if (exp_rd) begin
        n_chk++; if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rsp_rdata, exp_rdata); end
      end
      model_step(g);
      next_cycle();
    end
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    set_req(1, 0, 0, 14'h0, 32'h0, 4'h0);
    g = exp_grant(req_valid);
    model_step(g);
    next_cycle();
    model_step(-1);
  endtask

`ifdef SPRAM_ARB_STAT_EN
  task automatic test_stats();
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    set_req(1, 0, 0, 14'h0, 32'h0, 4'h0);
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (stat_grant_cnt !== '0 || stat_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stat_clr0: got %h/%h want 0/0", stat_grant_cnt, stat_stall_cnt); end
    next_cycle();
    set_req(0, 1, 0, 14'h0010, 32'h0, 4'h0);
    set_req(1, 1, 0, 14'h0020, 32'h0, 4'h0);
    repeat (10) next_cycle();
    set_req(0, 0, 0, 14'h0, 32'h0, 4'h0);
    set_req(1, 0, 0, 14'h0, 32'h0, 4'h0);
    @(negedge clk);
    n_chk++; if (stat_grant_cnt !== {16'd5, 16'd5}) begin n_fail++; $display("FAIL stat_grant: got %h want 00050005", stat_grant_cnt); end
    n_chk++; if (stat_stall_cnt !== 16'd10) begin n_fail++; $display("FAIL stat_stall: got %0d want 10", stat_stall_cnt); end
    next_cycle();
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (stat_grant_cnt !== '0 || stat_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stat_clr1: got %h/%h want 0/0", stat_grant_cnt, stat_stall_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_lock();
    test_reset_mid();
    test_random();
`ifdef SPRAM_ARB_STAT_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
